// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: sends one command byte with the request-to-send sequence.
// Latency: CLK_INHIBIT_CYCLES of clock inhibit, then one bit per device clock; line events seen 3 cycles late.
// Backpressure: tx_ready is high only in IDLE; tx_valid is ignored while a transfer is in flight.
//
// Optional build macro: PS2_TX_ACK_CHECK_EN -- a missing device ack pulses error instead of done.
//
// Ports:
//   CLOCK_50, reset        system clock, synchronous active-high reset
//   tx_data, tx_valid      command byte and send request (accepted when tx_ready is high)
//   tx_ready               high while idle
//   ps2_clk_in/ps2_dat_in  raw open-drain line levels (asynchronous)
//   ps2_clk_oe/ps2_dat_oe  1 = pull the line low, 0 = release (registered)
//   done, ack_ok           one-cycle completion pulse; ack_ok = device acknowledged
//   error                  one-cycle pulse on timeout (or missing ack with the macro)
module ps2_host_tx #(
  parameter int CLK_INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES     = 750000,
  parameter int CNT_W              = 20
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       done,
  output logic       ack_ok,
  output logic       error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_RELEASE,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_WAIT_IDLE
  } state_t;

  localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(CLK_INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] INH_PEN  = CNT_W'(CLK_INHIBIT_CYCLES - 2);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       shreg, shreg_n;
  logic             parity_bit, parity_n;
  logic [2:0]       bit_cnt, bit_cnt_n;
  logic             ack_seen, ack_seen_n;
  logic             clk_oe_n, dat_oe_n, done_n, ack_ok_n, error_n;

  // Line synchronizers; reset to the idle (released, high) level so no
  // spurious falling edge is seen when reset drops.
  logic clk_meta, clk_sync, clk_prev;
  logic dat_meta, dat_sync;
  logic fe;
  logic timing;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      clk_prev <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clk_in;
      clk_sync <= clk_meta;
      clk_prev <= clk_sync;
      dat_meta <= ps2_dat_in;
      dat_sync <= dat_meta;
    end
  end

  assign fe       = clk_prev & ~clk_sync;
  assign tx_ready = (state == S_IDLE);
  // Once the clock is handed to the device, every state waits on it.
  assign timing   = (state != S_IDLE) && (state != S_INHIBIT);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      shreg      <= '0;
      parity_bit <= 1'b0;
      bit_cnt    <= '0;
      ack_seen   <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      done       <= 1'b0;
      ack_ok     <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      shreg      <= shreg_n;
      parity_bit <= parity_n;
      bit_cnt    <= bit_cnt_n;
      ack_seen   <= ack_seen_n;
      ps2_clk_oe <= clk_oe_n;
      ps2_dat_oe <= dat_oe_n;
      done       <= done_n;
      ack_ok     <= ack_ok_n;
      error      <= error_n;
    end
  end

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    shreg_n    = shreg;
    parity_n   = parity_bit;
    bit_cnt_n  = bit_cnt;
    ack_seen_n = ack_seen;
    clk_oe_n   = ps2_clk_oe;
    dat_oe_n   = ps2_dat_oe;
    done_n     = 1'b0;
    ack_ok_n   = 1'b0;
    error_n    = 1'b0;

    case (state)
      S_IDLE: begin
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        cnt_n    = '0;
        if (tx_valid) begin
          shreg_n  = tx_data;
          parity_n = ~^tx_data;
          clk_oe_n = 1'b1;
          // With a one-cycle inhibit the first cycle is also the last one.
          dat_oe_n = (CLK_INHIBIT_CYCLES == 1);
          state_n  = S_INHIBIT;
        end
      end

      S_INHIBIT: begin
        if (cnt == INH_LAST) begin
          clk_oe_n = 1'b0;
          dat_oe_n = 1'b1;
          cnt_n    = '0;
          state_n  = S_RELEASE;
        end else begin
          clk_oe_n = 1'b1;
          cnt_n    = cnt + 1'b1;
          // Start bit goes onto the line during the last inhibit cycle.
          if (cnt == INH_PEN) dat_oe_n = 1'b1;
        end
      end

      S_RELEASE: begin
        if (fe) begin
          dat_oe_n  = ~shreg[0];
          shreg_n   = {1'b0, shreg[7:1]};
          bit_cnt_n = '0;
          state_n   = S_DATA;
        end
      end

      S_DATA: begin
        if (fe) begin
          if (bit_cnt == 3'd7) begin
            dat_oe_n = ~parity_bit;
            state_n  = S_PARITY;
          end else begin
            dat_oe_n  = ~shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
            bit_cnt_n = bit_cnt + 3'd1;
          end
        end
      end

      S_PARITY: begin
        if (fe) begin
          dat_oe_n = 1'b0;
          state_n  = S_STOP;
        end
      end

      S_STOP: begin
        if (fe) begin
          ack_seen_n = ~dat_sync;
          state_n    = S_WAIT_IDLE;
        end
      end

      S_WAIT_IDLE: begin
        if (clk_sync && dat_sync) begin
          state_n = S_IDLE;
          cnt_n   = '0;
`ifdef PS2_TX_ACK_CHECK_EN
          if (ack_seen) begin
            done_n   = 1'b1;
            ack_ok_n = 1'b1;
          end else begin
            error_n  = 1'b1;
          end
`else
          done_n   = 1'b1;
          ack_ok_n = ack_seen;
`endif
        end
      end

      default: begin
        state_n  = S_IDLE;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        cnt_n    = '0;
      end
    endcase

    // Device watchdog: restarts on every device clock edge; expiry abandons
    // the transfer regardless of what the state logic above decided.
    if (timing) begin
      if (fe) begin
        cnt_n = '0;
      end else if (cnt == TO_LAST) begin
        state_n  = S_IDLE;
        clk_oe_n = 1'b0;
        dat_oe_n = 1'b0;
        cnt_n    = '0;
        done_n   = 1'b0;
        ack_ok_n = 1'b0;
        error_n  = 1'b1;
      end else if (state_n != S_IDLE) begin
        cnt_n = cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int TMO = 200;
`ifdef PS2_TX_ACK_CHECK_EN
  localparam bit ACK_CHK = 1'b1;
`else
  localparam bit ACK_CHK = 1'b0;
`endif

  logic       CLOCK_50 = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] tx_data  = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       ps2_clk_oe, ps2_dat_oe, done, ack_ok, error;

  // Device side of the open-drain bus.
  logic dev_clk  = 1'b1;
  logic dev_pull = 1'b0;
  wire  clk_line = ~ps2_clk_oe & dev_clk;
  wire  dat_line = ~(ps2_dat_oe | dev_pull);

  ps2_host_tx #(.CLK_INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO), .CNT_W(20)) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .ps2_clk_in(clk_line),
    .ps2_dat_in(dat_line),
    .ps2_clk_oe(ps2_clk_oe),
    .ps2_dat_oe(ps2_dat_oe),
    .done      (done),
    .ack_ok    (ack_ok),
    .error     (error)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_chk = 0;
  int n_err = 0;

  // Free-running monitor on the falling edge.
  int cyc = 0;
  int inh_cnt = 0, ovl_cnt = 0, done_cnt = 0, err_cnt = 0, err_cyc = 0;
  logic done_ack = 1'b0, err_ack = 1'b0, err_oe = 1'b0;

  always @(posedge CLOCK_50) cyc <= cyc + 1;

  always @(negedge CLOCK_50) begin
    if (ps2_clk_oe) inh_cnt++;
    if (ps2_clk_oe && ps2_dat_oe) ovl_cnt++;
    if (done) begin
      done_cnt++;
      done_ack = ack_ok;
    end
    if (error) begin
      err_cnt++;
      err_cyc = cyc;
      err_ack = ack_ok;
      err_oe  = ps2_clk_oe | ps2_dat_oe;
    end
  end

  task automatic step();
    @(negedge CLOCK_50);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: a host frame is start 0, data LSB first, odd parity, stop 1.
  function automatic bit odd_par(input logic [7:0] d);
    return ($countones(d) % 2) == 0;
  endfunction

  typedef struct {
    logic [7:0] d;
    bit clocks;
    bit ack;
    bit busy;
    bit exp_done;
    bit exp_ack;
    bit exp_err;
    bit exp_par;
  } vec_t;

  task automatic run_txn(input vec_t v, input string tag);
    int d0 = done_cnt;
    int e0 = err_cnt;
    int i0 = inh_cnt;
    int o0 = ovl_cnt;
    int n = 0;
    int rel;
    logic [10:0] frame = '0;

    chk({tag, " ready_before"}, 32'(tx_ready), 32'd1);
    tx_data  = v.d;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    while (ps2_clk_oe && n < 100) begin
      step();
      n++;
    end
    chk({tag, " release_seen"}, 32'(n < 100), 32'd1);
    rel = cyc;
    chk({tag, " inhibit_cycles"}, 32'(inh_cnt - i0), 32'(INH));
    chk({tag, " start_overlap"}, 32'(ovl_cnt - o0), 32'd1);
    chk({tag, " start_driven"}, 32'(ps2_dat_oe), 32'd1);

    if (v.clocks) begin
      repeat (5) step();
      for (int p = 1; p <= 11; p++) begin
        if (p == 1) frame[0] = dat_line;
        dev_clk = 1'b0;
        if (p == 11 && v.ack) dev_pull = 1'b1;
        if (v.busy && p == 4) begin
          tx_data  = 8'h55;
          tx_valid = 1'b1;
          step();
          tx_valid = 1'b0;
          repeat (9) step();
        end else begin
          repeat (10) step();
        end
        if (p <= 10) frame[p] = dat_line;
        dev_clk  = 1'b1;
        dev_pull = 1'b0;
        repeat (10) step();
      end
    end

    n = 0;
    while (done_cnt == d0 && err_cnt == e0 && n < 400) begin
      step();
      n++;
    end
    chk({tag, " ready_after"}, 32'(tx_ready), 32'd1);
    if (v.clocks) begin
      chk({tag, " start_bit"}, 32'(frame[0]), 32'd0);
      chk({tag, " data_bits"}, 32'(frame[8:1]), 32'(v.d));
      chk({tag, " parity_bit"}, 32'(frame[9]), 32'(v.exp_par));
      chk({tag, " stop_bit"}, 32'(frame[10]), 32'd1);
    end
    if (v.exp_done) chk({tag, " ack_ok"}, 32'(done_ack), 32'(v.exp_ack));
    if (v.exp_err) begin
      chk({tag, " err_ack_ok"}, 32'(err_ack), 32'd0);
      chk({tag, " err_lines"}, 32'(err_oe), 32'd0);
    end
    if (!v.clocks) chk({tag, " timeout_cycles"}, 32'(err_cyc - rel), 32'(TMO));
    repeat (5) step();
    chk({tag, " done_pulses"}, 32'(done_cnt - d0), 32'(v.exp_done));
    chk({tag, " err_pulses"}, 32'(err_cnt - e0), 32'(v.exp_err));
    chk({tag, " idle_lines"}, {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
  endtask

  vec_t tbl[4];

  initial begin
    vec_t v;
    int d0, e0, n;

    tbl[0] = '{8'hED, 1, 1, 0, 1, 1, 0, 1};
    tbl[1] = '{8'hF4, 1, 1, 1, 1, 1, 0, 0};
    tbl[2] = '{8'hFF, 0, 0, 0, 0, 0, 1, 1};
    tbl[3] = '{8'h00, 1, 0, 0, !ACK_CHK, 0, ACK_CHK, 1};

    // Reset state
    repeat (3) step();
    chk("rst tx_ready", 32'(tx_ready), 32'd1);
    chk("rst oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("rst pulses", {29'd0, done, ack_ok, error}, 32'd0);
    reset = 1'b0;
    repeat (3) step();

    for (int i = 0; i < 4; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Reset in the middle of the data phase
    d0 = done_cnt;
    e0 = err_cnt;
    tx_data  = 8'hA5;
    tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    n = 0;
    while (ps2_clk_oe && n < 100) begin
      step();
      n++;
    end
    repeat (5) step();
    for (int p = 1; p <= 4; p++) begin
      dev_clk = 1'b0;
      repeat (10) step();
      dev_clk = 1'b1;
      if (p < 4) repeat (10) step();
    end
    repeat (3) step();
    chk("midrst busy", 32'(tx_ready), 32'd0);
    reset = 1'b1;
    step();
    chk("midrst oe", {30'd0, ps2_clk_oe, ps2_dat_oe}, 32'd0);
    chk("midrst ready", 32'(tx_ready), 32'd1);
    reset = 1'b0;
    repeat (30) step();
    chk("midrst no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
    v = '{8'h01, 1, 1, 0, 1, 1, 0, 0};
    run_txn(v, "after_rst");

    // Randomized traffic against the reference rules
    for (int r = 0; r < 6; r++) begin
      v.d        = 8'($urandom);
      v.clocks   = 1'b1;
      v.ack      = 1'($urandom_range(0, 1));
      v.busy     = 1'($urandom_range(0, 1));
      v.exp_par  = odd_par(v.d);
      v.exp_ack  = v.ack;
      v.exp_done = v.ack || !ACK_CHK;
      v.exp_err  = !v.ack && ACK_CHK;
      repeat ($urandom_range(0, 4)) step();
      run_txn(v, $sformatf("rnd%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
